// File: rtl/seq_adder_pkg.sv
// Shared definitions for the sequential chunked adder: state encoding and
// the counter-width helper.
package seq_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ceiling log2; returns 0 for n <= 1, so callers clamp to a minimum width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple slice built from full-adder cells; also
// exposes the carry into the top bit for signed-overflow detection.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    logic cy;
    s     = '0;
    cy    = cin;
    c_msb = cin;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb = cy;
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cout = cy;
  end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands are summed LSB-first, one
// CHUNK-bit slice per clock, with the carry registered between slices.
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   s,
  output logic             ovf
);

  localparam int NSL = WIDTH / CHUNK;
  localparam int CW  = (clog2(NSL) < 1) ? 1 : clog2(NSL);
  localparam logic [CW-1:0] LAST_IDX = CW'(NSL - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]   s_q, s_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] sl_a, sl_b, sl_s;
  logic             sl_cout, sl_cmsb;
  logic             accept, last;

  // A new operation is taken in IDLE or DONE; start during RUN is dropped.
  assign accept = start && (state_q != ST_RUN);
  assign last   = (idx_q == LAST_IDX);

  assign sl_a = CHUNK'(a_q >> (CHUNK * int'(idx_q)));
  assign sl_b = CHUNK'(b_q >> (CHUNK * int'(idx_q)));

  chunk_adder #(.CHUNK(CHUNK)) u_slice (
    .a     (sl_a),
    .b     (sl_b),
    .cin   (carry_q),
    .s     (sl_s),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      ST_RUN:           if (last) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    ovf_d   = ovf_q;
    if (accept) begin
      // Subtraction is a + ~b + 1: invert b once here and seed the carry.
      a_d     = a;
      b_d     = b ^ {WIDTH{sub}};
      carry_d = sub;
      idx_d   = '0;
      acc_d   = '0;
    end else if (state_q == ST_RUN) begin
      acc_d[CHUNK * int'(idx_q) +: CHUNK] = sl_s;
      carry_d = sl_cout;
      idx_d   = last ? '0 : idx_q + 1'b1;
      if (last) begin
        s_d   = {sl_cout, acc_d};
        ovf_d = sl_cmsb ^ sl_cout;
      end
    end
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    s    = s_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: a 16/4 instance and a degenerate
// 4/4 instance, directed vectors with hand-computed results.
module tb_seq_chunk_adder;

  logic clk;
  logic rst;

  logic        start16, sub16, busy16, done16, ovf16;
  logic [15:0] a16, b16;
  logic [16:0] s16;

  logic        start4, sub4, busy4, done4, ovf4;
  logic [3:0]  a4, b4;
  logic [4:0]  s4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] q16[$];  // {ovf, s}
  logic [5:0]  q4[$];

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .s(s16), .ovf(ovf16)
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .s(s4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop expected result whenever the DUT pulses done.
  always @(negedge clk) begin
    if (done16) begin
      if (q16.size() == 0) check("unexpected_done16", 32'd1, 32'd0);
      else check("result16", {14'd0, ovf16, s16}, {14'd0, q16.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      if (q4.size() == 0) check("unexpected_done4", 32'd1, 32'd0);
      else check("result4", {26'd0, ovf4, s4}, {26'd0, q4.pop_front()});
    end
  end

  // Drives start for one cycle; returns at the negedge after the accepting edge.
  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic push, input logic [16:0] exp_s, input logic exp_ovf);
    @(negedge clk);
    a16 = a; b16 = b; sub16 = sub; start16 = 1'b1;
    if (push) q16.push_back({exp_ovf, exp_s});
    @(negedge clk);
    start16 = 1'b0;
  endtask

  // Counts negedges (starting at n0) until done; checks latency and busy length.
  task automatic wait_done(input int sel, input int n0, input int exp_lat, input string name);
    int n;
    int busy_n;
    n = n0;
    busy_n = 0;
    while (!(sel == 0 ? done16 : done4) && n < 40) begin
      if (sel == 0 ? busy16 : busy4) busy_n++;
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, exp_lat);
    check({name, "_busy_cycles"}, busy_n, exp_lat - n0);
  endtask

  initial begin
    rst = 1'b1;
    start16 = 1'b0; sub16 = 1'b0; a16 = '0; b16 = '0;
    start4 = 1'b0;  sub4 = 1'b0;  a4 = '0;  b4 = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy16}, 32'd0);
    check("reset_done", {31'd0, done16}, 32'd0);
    check("reset_s",    {15'd0, s16},    32'd0);
    check("reset_ovf",  {31'd0, ovf16},  32'd0);
    check("reset_busy4", {31'd0, busy4}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: carry out of the full width
    issue16(16'hFFFF, 16'h0001, 1'b0, 1'b1, 17'h1_0000, 1'b0);
    wait_done(0, 1, 5, "t1");
    repeat (2) @(negedge clk);

    // 2: signed overflow, then subtraction with borrow
    issue16(16'h7FFF, 16'h0001, 1'b0, 1'b1, 17'h0_8000, 1'b1);
    wait_done(0, 1, 5, "t2a");
    repeat (2) @(negedge clk);
    issue16(16'h0005, 16'h0007, 1'b1, 1'b1, 17'h0_FFFE, 1'b0);
    wait_done(0, 1, 5, "t2b");
    repeat (2) @(negedge clk);
    // subtraction without borrow, and negative signed overflow
    issue16(16'h0007, 16'h0005, 1'b1, 1'b1, 17'h1_0002, 1'b0);
    wait_done(0, 1, 5, "t2c");
    repeat (2) @(negedge clk);
    issue16(16'h8000, 16'h0001, 1'b1, 1'b1, 17'h1_7FFF, 1'b1);
    wait_done(0, 1, 5, "t2d");
    repeat (2) @(negedge clk);

    // 3: start pulsed during RUN is ignored
    issue16(16'h1234, 16'h1111, 1'b0, 1'b1, 17'h0_2345, 1'b0);
    @(negedge clk);
    a16 = 16'hFFFF; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    wait_done(0, 3, 5, "t3");
    repeat (6) @(negedge clk);
    check("t3_idle_after", {31'd0, busy16}, 32'd0);

    // 4: reset mid-operation discards the result
    issue16(16'h00FF, 16'h0001, 1'b0, 1'b0, 17'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_busy", {31'd0, busy16}, 32'd0);
    check("t4_done", {31'd0, done16}, 32'd0);
    check("t4_s",    {15'd0, s16},    32'd0);
    check("t4_ovf",  {31'd0, ovf16},  32'd0);
    repeat (8) @(negedge clk);
    check("t4_still_idle", {31'd0, busy16}, 32'd0);

    // 5: back-to-back, new start accepted in the DONE cycle
    issue16(16'h8000, 16'h8000, 1'b0, 1'b1, 17'h1_0000, 1'b1);
    wait_done(0, 1, 5, "t5a");
    a16 = 16'h0010; b16 = 16'h0020; sub16 = 1'b0; start16 = 1'b1;
    q16.push_back({1'b0, 17'h0_0030});
    @(negedge clk);
    start16 = 1'b0;
    check("t5_busy_next", {31'd0, busy16}, 32'd1);
    check("t5_done_next", {31'd0, done16}, 32'd0);
    wait_done(0, 1, 5, "t5b");
    repeat (2) @(negedge clk);

    // 6: degenerate single-slice instance
    @(negedge clk);
    a4 = 4'h9; b4 = 4'h8; sub4 = 1'b0; start4 = 1'b1;
    q4.push_back({1'b1, 5'h11});
    @(negedge clk);
    start4 = 1'b0;
    wait_done(1, 1, 2, "t6");
    repeat (3) @(negedge clk);

    check("queue16_drained", q16.size(), 32'd0);
    check("queue4_drained",  q4.size(),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Multi-cycle, parametrised add/subtract unit. It is the next generation of the team's 4-bit ripple adder.
- Operands of WIDTH bits are processed LSB-first, one CHUNK-bit slice per clock, through a single combinational ripple slice.
- Carry is registered between slices.
- Start/busy/done handshake with a held result.
- Feeds the binary-to-hex display path, where wide sums must be formed without a long combinational carry chain.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per clock (ripple slice width); 1 <= CHUNK <= WIDTH.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when not busy.
sub  input  1  0 = a+b, 1 = a-b; latched with the operands.
a  input  WIDTH  operand A; latched on accepted start.
b  input  WIDTH  operand B; latched on accepted start.
busy  output  1  high while slices are being processed.
done  output  1  one-cycle pulse when s/ovf become valid.
s  output  WIDTH+1  result; s[WIDTH] is the carry-out (for sub: 1 = no borrow).
ovf  output  1  two's-complement signed overflow of the result.

Behaviour:
- Reset: synchronous, active-high. Sampled at a rising clk edge, it forces:
  - state = IDLE
  - busy = 0, done = 0, s = 0, ovf = 0
  - slice index = 0, carry register = 0
  - latched operands cleared
- Reset wins over every other input in the same cycle, including mid-operation: the partial result is discarded and no done is produced.
- NSL = WIDTH/CHUNK slices. Slice counter width is clog2(NSL), minimum 1.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1, edge E:
  - latch a
  - latch b XOR {WIDTH{sub}}
  - carry register = sub
  - index = 0
  - state -> RUN, busy = 1
- RUN, each edge:
  - slice[index] = a_slice + b_slice + carry
  - sum bits are written into the internal accumulator at slice position index
  - carry register <= slice carry-out
  - index increments
- On the last slice (index = NSL-1), at edge E+NSL:
  - s <= {carry_out, accumulator with final slice}
  - ovf <= carry_into_MSB XOR carry_out
  - state -> DONE, busy = 0, done = 1
- Latency: done is high in the cycle after edge E+NSL, i.e. NSL cycles after the start was accepted. Throughput is one operation per NSL+1 cycles, and back-to-back operation is permitted.
- DONE lasts exactly one cycle:
  - next edge -> IDLE with done = 0, or -> RUN if start = 1 (new op accepted, done = 0).
- s and ovf hold their last value until the next completion. They do not change during RUN.
- start while busy (RUN) is ignored entirely. It is not queued, and a/b/sub changes during RUN have no effect.
- Width rules:
  - all slice arithmetic is CHUNK+1 bits
  - the result is a modulo 2^WIDTH sum plus carry bit
  - no saturation
- Degenerate config CHUNK = WIDTH (NSL = 1): a single RUN cycle, so done follows one cycle after the accepted start.

Decomposition:
- Package seq_adder_pkg holds:
  - state encoding localparams ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2
  - the clog2 helper function used for the slice counter width
- Sub-module chunk_adder (parameter CHUNK): purely combinational ripple slice of full-adder cells.
  - Inputs: a, b [CHUNK-1:0], cin.
  - Outputs: s [CHUNK-1:0], cout, and c_msb (carry into bit CHUNK-1, used for ovf).
- seq_chunk_adder instantiates one chunk_adder, plus the FSM, slice counter, carry register, operand/accumulator registers and output registers.

Test Plan:
1. WIDTH=16, CHUNK=4: a=16'hFFFF, b=16'h0001, sub=0, start pulse -> busy for 4 cycles; done pulse in the 5th cycle after start; s=17'h1_0000, ovf=0.
2. a=16'h7FFF, b=16'h0001, sub=0 -> s=17'h0_8000, ovf=1. Then a=16'h0005, b=16'h0007, sub=1 -> s=17'h0_FFFE (carry=0, borrow), ovf=0.
3. Start op a=16'h1234, b=16'h1111. Pulse start again with a=16'hFFFF in RUN cycle 2 -> ignored; exactly one done; s=17'h0_2345.
4. Assert rst during RUN cycle 2 of op a=16'h00FF, b=16'h0001 -> next cycle busy=0, done=0, s=0, ovf=0; no done pulse afterwards until a new start.
5. Back-to-back: start held high through the DONE cycle with new operands a=16'h0010, b=16'h0020 -> first result valid with done, then busy=1 the next cycle; second done shows s=17'h0_0030.
6. WIDTH=4, CHUNK=4 instance: a=4'h9, b=4'h8, sub=0 -> done one cycle after start; s=5'h11, ovf=1.
